if_id_queue: RTL and testbench

Parametrised fetch-to-decode pipeline buffer carrying LANES instruction/PC pairs per entry through a DEPTH-entry FIFO with valid/ready handshakes on both sides. It replaces the single-register IF/ID latch. Fetch keeps issuing while decode is stalled, up to DEPTH entries, and a branch/jump flush empties the buffer in one cycle. It sits between the fetch stage (instruction cache side) and the decode stage of the pipelined datapath.

---
 rtl/if_id_queue.sv | 91 +++++++++
 tb/tb_if_id_queue.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - fetch-to-decode FIFO buffer of multi-lane instruction/PC entries
module if_id_queue #(
    parameter int LANES = 2,
    parameter int DW    = 32,
    parameter int DEPTH = 2
) (
    input  logic                          CLK,
    input  logic                          nRST,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [LANES*DW-1:0]           in_pc,
    input  logic [LANES*DW-1:0]           in_instr,
    input  logic [LANES-1:0]              in_mask,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*DW-1:0]           out_pc,
    output logic [LANES*DW-1:0]           out_instr,
    output logic [LANES-1:0]              out_mask,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [LANES*DW-1:0] r_pc    [DEPTH];
    logic [LANES*DW-1:0] r_instr [DEPTH];
    logic [LANES-1:0]    r_mask  [DEPTH];
    logic [PW-1:0]       r_rd_ptr;
    logic [PW-1:0]       r_wr_ptr;
    logic [CW-1:0]       r_count;

    logic w_push;
    logic w_pop;

    // Handshake flags come only from the registered occupancy.
    assign in_ready  = (r_count != FULL);
    assign out_valid = (r_count != '0);
    assign count     = r_count;

    assign w_push = in_valid & in_ready & ~flush;
    assign w_pop  = out_valid & out_ready & ~flush;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc[i]    <= '0;
                r_instr[i] <= '0;
                r_mask[i]  <= '0;
            end
        end else if (flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_pc[r_wr_ptr]    <= in_pc;
                r_instr[r_wr_ptr] <= in_instr;
                r_mask[r_wr_ptr]  <= in_mask;
                r_wr_ptr          <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Empty buffer presents an all-zero bubble; masked lanes become nops.
    always_comb begin
        out_pc    = '0;
        out_instr = '0;
        out_mask  = '0;
        if (out_valid) begin
            out_pc   = r_pc[r_rd_ptr];
            out_mask = r_mask[r_rd_ptr];
            for (int i = 0; i < LANES; i++) begin
                out_instr[i*DW +: DW] = r_mask[r_rd_ptr][i] ? r_instr[r_rd_ptr][i*DW +: DW] : '0;
            end
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - scoreboard bench for if_id_queue (LANES=2, DW=32, DEPTH=2)
module tb_if_id_queue;

    localparam int LANES = 2;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic                CLK;
    logic                nRST;
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [LANES*DW-1:0] in_pc;
    logic [LANES*DW-1:0] in_instr;
    logic [LANES-1:0]    in_mask;
    logic                out_valid;
    logic                out_ready;
    logic [LANES*DW-1:0] out_pc;
    logic [LANES*DW-1:0] out_instr;
    logic [LANES-1:0]    out_mask;
    logic [1:0]          count;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] instr;
        logic [1:0]  mask;
    } entry_t;

    entry_t q[$];
    int checks   = 0;
    int failures = 0;

    if_id_queue #(.LANES(LANES), .DW(DW), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .nRST(nRST), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instr(out_instr), .out_mask(out_mask),
        .count(count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        entry_t e;
        check({tag, ".in_ready"}, 64'(in_ready), 64'(q.size() != DEPTH));
        check({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() != 0));
        check({tag, ".count"}, 64'(count), 64'(q.size()));
        if (q.size() != 0) begin
            e = q[0];
            check({tag, ".out_pc"}, out_pc, e.pc);
            check({tag, ".out_instr"}, out_instr, e.instr);
            check({tag, ".out_mask"}, 64'(out_mask), 64'(e.mask));
        end else begin
            check({tag, ".bubble"}, {out_pc ^ out_instr, 62'(0), out_mask}, 64'(0));
        end
    endtask

    // Drives one cycle of stimulus, checks the current head, then advances the model.
    task automatic step(input string tag, input logic v, input logic [63:0] pc,
                        input logic [63:0] ins, input logic [1:0] m,
                        input logic rdy, input logic fl);
        entry_t e;
        logic   mpush;
        logic   mpop;
        in_valid  = v;
        in_pc     = pc;
        in_instr  = ins;
        in_mask   = m;
        out_ready = rdy;
        flush     = fl;
        check_outputs(tag);
        mpush = v && (q.size() != DEPTH) && !fl;
        mpop  = (q.size() != 0) && rdy && !fl;
        if (fl) q.delete();
        if (mpop) void'(q.pop_front());
        if (mpush) begin
            e.pc    = pc;
            e.instr = {m[1] ? ins[63:32] : 32'h0, m[0] ? ins[31:0] : 32'h0};
            e.mask  = m;
            q.push_back(e);
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        nRST = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_instr = '0; in_mask = '0;
        repeat (2) @(posedge CLK);
        #1;
        check_outputs("reset");
        nRST = 1'b1;
        step("idle", 1'b0, 64'h0, 64'h0, 2'b00, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            step("stream", 1'b1, {32'(8*i+4), 32'(8*i)},
                 {32'h2002_0001 + 32'(i), 32'h8C01_0000 + 32'(i)}, 2'b11, 1'b1, 1'b0);
        end
        step("stream_tail", 1'b0, 64'h0, 64'h0, 2'b00, 1'b1, 1'b0);

        step("bp0", 1'b1, 64'h0000_0104_0000_0100, 64'hAAAA_0001_BBBB_0001, 2'b11, 1'b0, 1'b0);
        step("bp1", 1'b1, 64'h0000_010C_0000_0108, 64'hAAAA_0002_BBBB_0002, 2'b10, 1'b0, 1'b0);
        step("bp2", 1'b1, 64'h0000_0114_0000_0110, 64'hAAAA_0003_BBBB_0003, 2'b11, 1'b0, 1'b0);
        step("full_pop", 1'b1, 64'h0000_011C_0000_0118, 64'hAAAA_0004_BBBB_0004, 2'b11, 1'b1, 1'b0);
        step("drain0", 1'b0, 64'h0, 64'h0, 2'b00, 1'b1, 1'b0);
        step("drain1", 1'b0, 64'h0, 64'h0, 2'b00, 1'b1, 1'b0);

        step("mask_push", 1'b1, 64'h0000_0104_0000_0100, 64'hFFFF_FFFF_0000_1234, 2'b01, 1'b0, 1'b0);
        step("mask_hold", 1'b0, 64'h0, 64'h0, 2'b00, 1'b0, 1'b0);
        step("flush", 1'b1, 64'h0000_0204_0000_0200, 64'hDEAD_BEEF_CAFE_F00D, 2'b11, 1'b1, 1'b1);
        step("post_flush", 1'b0, 64'h0, 64'h0, 2'b00, 1'b1, 1'b0);

        step("ar_fill0", 1'b1, 64'h0000_0304_0000_0300, 64'h1111_0000_2222_0000, 2'b11, 1'b0, 1'b0);
        step("ar_fill1", 1'b1, 64'h0000_030C_0000_0308, 64'h3333_0000_4444_0000, 2'b11, 1'b0, 1'b0);
        in_valid = 1'b0;
        check("ar_pre.count", 64'(count), 64'd2);
        #3;
        nRST = 1'b0;
        #1;
        q.delete();
        check_outputs("async_reset");
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        step("after_reset", 1'b0, 64'h0, 64'h0, 2'b00, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
